// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [ADDR_W-1:0]  DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEF_PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, registered output word with valid/ready
// handshake, branch redirect/flush, halt/resume and a saturating fetch counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = DEF_RESET_PC,
    parameter logic [ADDR_W-1:0]  PC_STEP   = DEF_PC_STEP,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               resume,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cap;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign cap = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        count_d     = count_q;

        // Redirect overrides everything, including a pending resume or handshake.
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
        end else if (cap) begin
            out_instr_d = imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            count_d     = sat_inc(count_q);
            if (imem_data == HALT_WORD) begin
                state_d = ST_HALTED;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (state_q == ST_HALTED && resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            count_q     <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a rule-level model of the fetch stage.
module tb_fetch_unit;

    // ~addr equals the default halt word at address 0, so the DUT gets a halt
    // encoding that the ~addr memory never produces in the ranges exercised.
    localparam logic [31:0] HALT_W = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        resume = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_opc;
    logic        m_valid, m_halted;
    logic [15:0] m_count;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .resume        (resume),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (halt_en && a == halt_addr) ? HALT_W : ~a;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_opc    = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_count  = 16'h0;
    endtask

    // One clock edge of the fetch rules, using the inputs present at the edge.
    task automatic model_step();
        logic take;
        logic [31:0] w;
        take = !m_halted && (!m_valid || out_ready) && !redirect_valid;
        if (redirect_valid) begin
            m_pc     = redirect_pc;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (take) begin
            w       = mem_word(m_pc);
            m_instr = w;
            m_opc   = m_pc;
            m_valid = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (w == HALT_W) m_halted = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_halted && resume) m_halted = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("halted", {31'h0, halted}, {31'h0, m_halted});
        chk("fetch_count", {16'h0, fetch_count}, {16'h0, m_count});
        if (m_valid) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_pc", out_pc, m_opc);
        end
    endtask

    // Advance one edge, update the model, check 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        cyc();
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("por_out_valid", {31'h0, out_valid}, 32'h0);
        chk("por_out_instr", out_instr, 32'h0);
        chk("por_out_pc", out_pc, 32'h0);
        chk("por_halted", {31'h0, halted}, 32'h0);
        chk("por_count", {16'h0, fetch_count}, 32'h0);
        chk("por_imem_addr", imem_addr, 32'h0);
        cyc();
        #2 rst = 1'b0;

        // Straight-line fetch
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_pc", out_pc, 32'(i * 4));
            chk("seq_instr", out_instr, ~32'(i * 4));
        end
        chk("seq_count4", {16'h0, fetch_count}, 32'd4);

        // Backpressure at out_pc=8
        do_reset();
        cyc(); cyc(); cyc();
        chk("bp_at8", out_pc, 32'h8);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_pc", out_pc, 32'h8);
            chk("bp_hold_addr", imem_addr, 32'hC);
            chk("bp_hold_cnt", {16'h0, fetch_count}, 32'd3);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_resume_pc", out_pc, 32'hC);
        cyc();
        chk("bp_next_pc", out_pc, 32'h10);

        // Redirect while a word is held
        out_ready = 1'b0;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cyc();
        redirect_valid = 1'b0;
        chk("rd_flush", {31'h0, out_valid}, 32'h0);
        cyc();
        chk("rd_tgt_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        cyc();
        chk("rd_tgt_next", out_pc, 32'h104);

        // Halt at 0x10, resume
        do_reset();
        halt_en = 1'b1;
        halt_addr = 32'h10;
        for (int i = 0; i < 5; i++) cyc();
        chk("halt_pc", out_pc, 32'h10);
        chk("halt_word", out_instr, HALT_W);
        chk("halt_flag", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 5; i++) cyc();
        chk("halt_cnt", {16'h0, fetch_count}, 32'd5);
        chk("halt_idle", {31'h0, out_valid}, 32'h0);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("resume_flag", {31'h0, halted}, 32'h0);
        cyc();
        chk("resume_pc", out_pc, 32'h14);
        halt_en = 1'b0;

        // Async reset pulse mid-stall
        out_ready = 1'b0;
        cyc(); cyc();
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_instr", out_instr, 32'h0);
        chk("arst_cnt", {16'h0, fetch_count}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("arst_restart_pc", out_pc, 32'h0);
        chk("arst_restart_valid", {31'h0, out_valid}, 32'h1);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("wrap_0", out_pc, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_1", out_pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_2", out_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32'h0FFF)
                                                         : ($urandom_range(0, 32'h0FFF) & 32'hFFFF_FFFC);
            resume         = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                halt_en   = 1'b1;
                halt_addr = m_pc + 32'(4 * $urandom_range(0, 3));
            end
            cyc();
        end
        redirect_valid = 1'b0;
        resume = 1'b0;
        halt_en = 1'b0;

        // Counter saturation
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 65540; i++) cyc();
        chk("sat_count", {16'h0, fetch_count}, 32'h0000_FFFF);
        cyc();
        chk("sat_hold", {16'h0, fetch_count}, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
